// File: rtl/jstk2_spi_responder_if.sv
// SPI pin bundle between a PmodJSTK2-style master and the joystick responder.
// The master drives the clock, select and data-out; the responder drives MISO and its pad enable.
interface jstk2_spi_responder_if;
  logic sck;
  logic cs_n;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output sck, output cs_n, output mosi, input miso, input miso_oe);
  modport slave  (input sck, input cs_n, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/jstk2_spi_responder.sv
// SPI mode-0 responder emulating the PmodJSTK2: reports snapshotted X/Y/buttons,
// captures the master's command bytes and decodes the set-LED command into an RGB register.
module jstk2_spi_responder #(
  parameter int          SYNC_STAGES = 2,
  parameter int          NUM_BYTES   = 5,
  parameter logic [7:0]  CMD_SET_LED = 8'h84
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  jstk2_spi_responder_if.slave io_spi,
  input  logic [9:0]           i_x_in,
  input  logic [9:0]           i_y_in,
  input  logic [1:0]           i_btn_in,
  output logic [7:0]           o_cmd_byte,
  output logic [23:0]          o_led_rgb,
  output logic                 o_frame_done,
  output logic                 o_frame_err
);

  localparam logic [5:0] FRAME_BITS = 6'(NUM_BYTES * 8);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_CLOSE} state_t;

  // Reset asserts asynchronously but releases only on a clock edge.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_d;
  logic                   r_cs_d;
  logic                   w_sck_s, w_cs_s, w_mosi_s;
  logic                   w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;

  // CS_n synchroniser resets to the deselected level so reset release never looks like a frame start.
  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_d     <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], io_spi.sck};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], io_spi.cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], io_spi.mosi};
      r_sck_d     <= w_sck_s;
      r_cs_d      <= w_cs_s;
    end
  end

  assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
  assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise =  w_sck_s & ~r_sck_d;
  assign w_sck_fall = ~w_sck_s &  r_sck_d;
  assign w_cs_fall  = ~w_cs_s  &  r_cs_d;
  assign w_cs_rise  =  w_cs_s  & ~r_cs_d;

  function automatic logic [7:0] f_tx_byte(input logic [2:0] idx, input logic [9:0] x,
                                           input logic [9:0] y, input logic [1:0] btn);
    logic [7:0] b;
    b = 8'h00;
    if (int'(idx) < NUM_BYTES) begin
      case (idx)
        3'd0:    b = x[7:0];
        3'd1:    b = {6'b0, x[9:8]};
        3'd2:    b = y[7:0];
        3'd3:    b = {6'b0, y[9:8]};
        3'd4:    b = {6'b0, btn};
        default: b = 8'h00;
      endcase
    end
    return b;
  endfunction

  state_t     r_state;
  logic [9:0] r_x_shadow, r_y_shadow;
  logic [1:0] r_btn_shadow;
  logic [7:0] r_tx_shift;
  logic [2:0] r_tx_idx;
  logic [2:0] r_tx_bitpos;
  logic [5:0] r_bit_cnt;
  logic [7:0] r_rx_shift;
  logic [7:0] r_rx_buf [NUM_BYTES];
  logic       r_miso, r_miso_oe;
  logic [7:0] r_cmd_byte;
  logic [23:0] r_led_rgb;
  logic       r_frame_done, r_frame_err;

  logic [7:0] w_rx_next;
  logic [2:0] w_tx_next_idx;
  logic [7:0] w_tx_next_byte;
  logic [7:0] w_tx_first_byte;

  assign w_rx_next       = {r_rx_shift[6:0], w_mosi_s};
  assign w_tx_next_idx   = (r_tx_idx == 3'd7) ? 3'd7 : r_tx_idx + 3'd1;
  assign w_tx_next_byte  = f_tx_byte(w_tx_next_idx, r_x_shadow, r_y_shadow, r_btn_shadow);
  assign w_tx_first_byte = f_tx_byte(3'd0, i_x_in, i_y_in, i_btn_in);

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state      <= S_IDLE;
      r_x_shadow   <= '0;
      r_y_shadow   <= '0;
      r_btn_shadow <= '0;
      r_tx_shift   <= '0;
      r_tx_idx     <= '0;
      r_tx_bitpos  <= '0;
      r_bit_cnt    <= '0;
      r_rx_shift   <= '0;
      for (int i = 0; i < NUM_BYTES; i++) r_rx_buf[i] <= '0;
      r_miso       <= 1'b0;
      r_miso_oe    <= 1'b0;
      r_cmd_byte   <= '0;
      r_led_rgb    <= '0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cs_fall) begin
            r_x_shadow   <= i_x_in;
            r_y_shadow   <= i_y_in;
            r_btn_shadow <= i_btn_in;
            r_tx_shift   <= w_tx_first_byte;
            r_miso       <= w_tx_first_byte[7];
            r_miso_oe    <= 1'b1;
            r_tx_idx     <= '0;
            r_tx_bitpos  <= '0;
            r_bit_cnt    <= '0;
            r_state      <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (w_cs_rise) begin
            r_miso_oe <= 1'b0;
            r_miso    <= 1'b0;
            r_state   <= S_CLOSE;
          end else begin
            if (w_sck_rise) begin
              r_rx_shift <= w_rx_next;
              if (r_bit_cnt != 6'd63) r_bit_cnt <= r_bit_cnt + 6'd1;
              if (r_bit_cnt[2:0] == 3'd7 && int'(r_bit_cnt[5:3]) < NUM_BYTES)
                r_rx_buf[r_bit_cnt[5:3]] <= w_rx_next;
            end
            // MISO changes on the falling edge so the master samples a stable bit on the rise.
            if (w_sck_fall) begin
              if (r_tx_bitpos == 3'd7) begin
                r_tx_idx    <= w_tx_next_idx;
                r_tx_shift  <= w_tx_next_byte;
                r_miso      <= w_tx_next_byte[7];
                r_tx_bitpos <= '0;
              end else begin
                r_tx_shift  <= {r_tx_shift[6:0], 1'b0};
                r_miso      <= r_tx_shift[6];
                r_tx_bitpos <= r_tx_bitpos + 3'd1;
              end
            end
          end
        end
        S_CLOSE: begin
          if (r_bit_cnt == FRAME_BITS) begin
            r_frame_done <= 1'b1;
            r_cmd_byte   <= r_rx_buf[0];
            if (r_rx_buf[0] == CMD_SET_LED)
              r_led_rgb <= {r_rx_buf[1], r_rx_buf[2], r_rx_buf[3]};
          end else begin
            r_frame_err <= 1'b1;
          end
          r_bit_cnt   <= '0;
          r_tx_idx    <= '0;
          r_tx_bitpos <= '0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_spi.miso    = r_miso;
  assign io_spi.miso_oe = r_miso_oe;
  assign o_cmd_byte     = r_cmd_byte;
  assign o_led_rgb      = r_led_rgb;
  assign o_frame_done   = r_frame_done;
  assign o_frame_err    = r_frame_err;

endmodule

// File: tb/tb_jstk2_spi_responder.sv
// Directed bench for jstk2_spi_responder: a behavioural SPI mode-0 master clocks frames
// and checks returned MISO bytes, status pulses and the command/LED registers.
module tb_jstk2_spi_responder;
  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  x_in, y_in;
  logic [1:0]  btn_in;
  logic [7:0]  cmd_byte;
  logic [23:0] led_rgb;
  logic        frame_done, frame_err;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [7:0] m_tx [0:7];
  logic [7:0] m_rx [0:7];
  logic       m_oe;

  always #5 clk = ~clk;

  jstk2_spi_responder_if spi ();

  jstk2_spi_responder #(
    .SYNC_STAGES (2),
    .NUM_BYTES   (5),
    .CMD_SET_LED (8'h84)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .io_spi       (spi.slave),
    .i_x_in       (x_in),
    .i_y_in       (y_in),
    .i_btn_in     (btn_in),
    .o_cmd_byte   (cmd_byte),
    .o_led_rgb    (led_rgb),
    .o_frame_done (frame_done),
    .o_frame_err  (frame_err)
  );

  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (frame_err)  err_cnt++;
  end

  // Clock nbits bits; change x_in after bit chg_bit; assert reset after bit rst_bit and abort.
  task automatic spi_frame(input int nbits, input int chg_bit, input int rst_bit);
    for (int i = 0; i < 8; i++) m_rx[i] = 8'h00;
    @(negedge clk);
    spi.cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int b = 0; b < nbits; b++) begin
      spi.mosi = m_tx[b/8][7-(b%8)];
      repeat (HALF) @(negedge clk);
      m_rx[b/8][7-(b%8)] = spi.miso;
      if (b == 0) m_oe = spi.miso_oe;
      spi.sck = 1'b1;
      repeat (HALF) @(negedge clk);
      spi.sck = 1'b0;
      if (b == chg_bit) x_in = 10'h000;
      if (b == rst_bit) begin
        rst_n = 1'b0;
        @(negedge clk);
        n_vec++;
        if (spi.miso_oe !== 1'b0) begin
          n_err++;
          $display("FAIL rst_mid_oe: got %b want 0", spi.miso_oe);
        end
        spi.cs_n = 1'b1;
        spi.mosi = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        return;
      end
    end
    repeat (HALF) @(negedge clk);
    spi.cs_n = 1'b1;
    spi.mosi = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    spi.cs_n = 1'b1; spi.sck = 1'b0; spi.mosi = 1'b0;
    x_in = '0; y_in = '0; btn_in = '0;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_vec += 6;
    if (spi.miso !== 1'b0)     begin n_err++; $display("FAIL reset_miso: got %b want 0", spi.miso); end
    if (spi.miso_oe !== 1'b0)  begin n_err++; $display("FAIL reset_oe: got %b want 0", spi.miso_oe); end
    if (cmd_byte !== 8'h00)    begin n_err++; $display("FAIL reset_cmd: got %h want 00", cmd_byte); end
    if (led_rgb !== 24'h0)     begin n_err++; $display("FAIL reset_led: got %h want 000000", led_rgb); end
    if (frame_done !== 1'b0)   begin n_err++; $display("FAIL reset_done: got %b want 0", frame_done); end
    if (frame_err !== 1'b0)    begin n_err++; $display("FAIL reset_err: got %b want 0", frame_err); end
    $display("test_reset: outputs idle after reset");
  endtask

  task automatic test_unknown_cmd();
    logic [7:0] exp_b [0:4];
    int d0, e0;
    exp_b = '{8'hA5, 8'h02, 8'h1F, 8'h01, 8'h02};
    x_in = 10'h2A5; y_in = 10'h11F; btn_in = 2'b10;
    m_tx = '{8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    d0 = done_cnt; e0 = err_cnt;
    spi_frame(40, -1, -1);
    for (int k = 0; k < 5; k++) begin
      n_vec++;
      if (m_rx[k] !== exp_b[k]) begin n_err++; $display("FAIL unk_miso_b%0d: got %h want %h", k, m_rx[k], exp_b[k]); end
    end
    n_vec += 5;
    if (m_oe !== 1'b1)           begin n_err++; $display("FAIL unk_oe: got %b want 1", m_oe); end
    if (done_cnt - d0 !== 1)     begin n_err++; $display("FAIL unk_done: got %0d pulses want 1", done_cnt - d0); end
    if (err_cnt - e0 !== 0)      begin n_err++; $display("FAIL unk_err: got %0d pulses want 0", err_cnt - e0); end
    if (cmd_byte !== 8'hC0)      begin n_err++; $display("FAIL unk_cmd: got %h want C0", cmd_byte); end
    if (led_rgb !== 24'h0)       begin n_err++; $display("FAIL unk_led: got %h want 000000", led_rgb); end
    $display("test_unknown_cmd: frame C0 -> miso %h %h %h %h %h cmd %h", m_rx[0], m_rx[1], m_rx[2], m_rx[3], m_rx[4], cmd_byte);
  endtask

  task automatic test_set_led();
    int d0;
    m_tx = '{8'h84, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00};
    d0 = done_cnt;
    spi_frame(40, -1, -1);
    n_vec += 4;
    if (done_cnt - d0 !== 1)   begin n_err++; $display("FAIL led_done: got %0d pulses want 1", done_cnt - d0); end
    if (cmd_byte !== 8'h84)    begin n_err++; $display("FAIL led_cmd: got %h want 84", cmd_byte); end
    if (led_rgb !== 24'h112233) begin n_err++; $display("FAIL led_rgb: got %h want 112233", led_rgb); end
    if (m_rx[4] !== 8'h02)     begin n_err++; $display("FAIL led_miso_b4: got %h want 02", m_rx[4]); end
    $display("test_set_led: frame 84 11 22 33 -> led %h cmd %h", led_rgb, cmd_byte);
  endtask

  task automatic test_short_frame();
    int d0, e0;
    m_tx = '{8'h84, 8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    d0 = done_cnt; e0 = err_cnt;
    spi_frame(24, -1, -1);
    n_vec += 4;
    if (err_cnt - e0 !== 1)     begin n_err++; $display("FAIL short_err: got %0d pulses want 1", err_cnt - e0); end
    if (done_cnt - d0 !== 0)    begin n_err++; $display("FAIL short_done: got %0d pulses want 0", done_cnt - d0); end
    if (led_rgb !== 24'h112233) begin n_err++; $display("FAIL short_led: got %h want 112233", led_rgb); end
    if (cmd_byte !== 8'h84)     begin n_err++; $display("FAIL short_cmd: got %h want 84", cmd_byte); end
    $display("test_short_frame: 24-bit frame -> led %h cmd %h", led_rgb, cmd_byte);
  endtask

  task automatic test_snapshot();
    int d0;
    x_in = 10'h3FF;
    m_tx = '{8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    d0 = done_cnt;
    spi_frame(40, 12, -1);
    n_vec += 4;
    if (m_rx[0] !== 8'hFF)   begin n_err++; $display("FAIL snap_b0: got %h want FF", m_rx[0]); end
    if (m_rx[1] !== 8'h03)   begin n_err++; $display("FAIL snap_b1: got %h want 03", m_rx[1]); end
    if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL snap_done: got %0d pulses want 1", done_cnt - d0); end
    if (cmd_byte !== 8'hC0)  begin n_err++; $display("FAIL snap_cmd: got %h want C0", cmd_byte); end
    $display("test_snapshot: x changed mid-frame -> miso %h %h", m_rx[0], m_rx[1]);
  endtask

  task automatic test_long_frame();
    logic [7:0] exp_b [0:6];
    int d0, e0;
    exp_b = '{8'hA5, 8'h02, 8'h1F, 8'h01, 8'h02, 8'h00, 8'h00};
    x_in = 10'h2A5; y_in = 10'h11F; btn_in = 2'b10;
    m_tx = '{8'h84, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00};
    d0 = done_cnt; e0 = err_cnt;
    spi_frame(56, -1, -1);
    for (int k = 0; k < 7; k++) begin
      n_vec++;
      if (m_rx[k] !== exp_b[k]) begin n_err++; $display("FAIL long_miso_b%0d: got %h want %h", k, m_rx[k], exp_b[k]); end
    end
    n_vec += 4;
    if (err_cnt - e0 !== 1)     begin n_err++; $display("FAIL long_err: got %0d pulses want 1", err_cnt - e0); end
    if (done_cnt - d0 !== 0)    begin n_err++; $display("FAIL long_done: got %0d pulses want 0", done_cnt - d0); end
    if (cmd_byte !== 8'hC0)     begin n_err++; $display("FAIL long_cmd: got %h want C0", cmd_byte); end
    if (led_rgb !== 24'h112233) begin n_err++; $display("FAIL long_led: got %h want 112233", led_rgb); end
    $display("test_long_frame: 7-byte frame -> b5 %h b6 %h cmd %h", m_rx[5], m_rx[6], cmd_byte);
  endtask

  task automatic test_reset_mid_frame();
    int d0, e0;
    m_tx = '{8'h84, 8'h44, 8'h55, 8'h66, 8'h00, 8'h00, 8'h00, 8'h00};
    d0 = done_cnt; e0 = err_cnt;
    spi_frame(40, -1, 20);
    n_vec += 4;
    if (done_cnt - d0 !== 0) begin n_err++; $display("FAIL rst_mid_done: got %0d pulses want 0", done_cnt - d0); end
    if (err_cnt - e0 !== 0)  begin n_err++; $display("FAIL rst_mid_err: got %0d pulses want 0", err_cnt - e0); end
    if (led_rgb !== 24'h0)   begin n_err++; $display("FAIL rst_mid_led: got %h want 000000", led_rgb); end
    if (spi.miso_oe !== 1'b0) begin n_err++; $display("FAIL rst_mid_oe_after: got %b want 0", spi.miso_oe); end
    m_tx = '{8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    d0 = done_cnt;
    spi_frame(40, -1, -1);
    n_vec += 4;
    if (m_rx[0] !== 8'hA5)   begin n_err++; $display("FAIL rst_next_b0: got %h want A5", m_rx[0]); end
    if (m_rx[3] !== 8'h01)   begin n_err++; $display("FAIL rst_next_b3: got %h want 01", m_rx[3]); end
    if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL rst_next_done: got %0d pulses want 1", done_cnt - d0); end
    if (cmd_byte !== 8'hC0)  begin n_err++; $display("FAIL rst_next_cmd: got %h want C0", cmd_byte); end
    $display("test_reset_mid_frame: aborted frame, next frame miso %h %h cmd %h", m_rx[0], m_rx[1], cmd_byte);
  endtask

  initial begin
    test_reset();
    test_unknown_cmd();
    test_set_led();
    test_short_frame();
    test_snapshot();
    test_long_frame();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
